// File: rtl/amiq_i2c_ex_slave.sv
// ----------------------------------------------------------------------------
// amiq_i2c_ex_slave
// I2C target with a small byte register file. A write transfer sets the
// register pointer and then writes bytes; a read transfer returns bytes from
// the pointer onward. SDA is driven open-drain through sda_o/sda_o_en; SCL is
// never driven or stretched.
//
// Ports
//   clock        system clock, at least 16x the SCL rate
//   reset_n      asynchronous active-low reset
//   scl_i        resolved bus SCL
//   sda_i        resolved bus SDA
//   sda_o        SDA drive value, always 0
//   sda_o_en     1 = pull SDA low, 0 = release
//   busy         high from an address-matched START until STOP
//   wr_strobe    one-cycle pulse per data byte written
//   wr_addr      register index of the write flagged by wr_strobe
//   wr_data      data of the write flagged by wr_strobe
//   dbg_state_o  current FSM state (debug)
//   dbg_ptr_o    current register pointer (debug)
//
// Write-port semantics: wr_strobe is a valid-only pulse with no back-pressure;
// wr_addr/wr_data are meaningful only in the cycle wr_strobe is high.
// ----------------------------------------------------------------------------
module amiq_i2c_ex_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         MEM_DEPTH   = 16,
  parameter int         PTR_W       = 4,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_o_en,
  output logic             busy,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [3:0]       dbg_state_o,
  output logic [PTR_W-1:0] dbg_ptr_o
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_WAIT_STOP = 4'd9;

  localparam int               HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  // Synchronizers plus one history flop for edge detection. They reset to 1
  // (idle bus) so leaving reset never looks like a START or STOP.
  logic scl_s1_q, scl_s_q, scl_prev_q;
  logic sda_s1_q, sda_s_q, sda_prev_q;

  logic [3:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              oe_q, oe_d;
  logic              pend_q, pend_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              strobe_q, strobe_d;
  logic [PTR_W-1:0]  wa_q, wa_d;
  logic [7:0]        wd_q, wd_d;
  logic [7:0]        mem_q [MEM_DEPTH];
  logic              mem_we;
  logic [7:0]        rx_byte;

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_s_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s_q & scl_prev_q;
  assign start_det = sda_prev_q & ~sda_s_q & scl_s_q;
  assign stop_det  = ~sda_prev_q & sda_s_q & scl_s_q;
  assign rx_byte   = {sh_q[6:0], sda_s_q};
  assign ptr_inc   = ptr_q + PTR_ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    busy_d   = busy_q;
    oe_d     = oe_q;
    pend_d   = pend_q;
    hold_d   = hold_q;
    strobe_d = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    mem_we   = 1'b0;

    // Hold timer: the SDA drive value chosen at the SCL falling edge is
    // applied only once the timer runs out, keeping SDA stable around SCL.
    if (hold_q != '0) begin
      hold_d = hold_q - HOLD_ONE;
      if (hold_q == HOLD_ONE) oe_d = pend_q;
    end

    // Bus conditions win over bit sampling; a partial byte is dropped.
    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      hold_d  = '0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      hold_d  = '0;
      busy_d  = 1'b0;
    end else if (scl_fall) begin
      hold_d = HOLD_INIT;
      case (state_q)
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: pend_d = 1'b1;
        ST_RDATA:                              pend_d = ~sh_q[7];
        default:                               pend_d = 1'b0;
      endcase
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA: begin
          // In RDATA the shift also moves the next read bit into sh_q[7].
          sh_d  = rx_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            case (state_q)
              ST_ADDR: begin
                rw_d = sda_s_q;
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  busy_d  = 1'b1;
                  state_d = ST_ADDR_ACK;
                end else begin
                  state_d = ST_WAIT_STOP;
                end
              end
              ST_PTR: begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = ST_PTR_ACK;
              end
              ST_WDATA: begin
                mem_we   = 1'b1;
                strobe_d = 1'b1;
                wa_d     = ptr_q;
                wd_d     = rx_byte;
                ptr_d    = ptr_inc;
                state_d  = ST_WDATA_ACK;
              end
              default: state_d = ST_RDATA_ACK;
            endcase
          end
        end
        ST_ADDR_ACK: begin
          if (rw_q) begin
            sh_d    = mem_q[ptr_q];
            state_d = ST_RDATA;
          end else begin
            state_d = ST_PTR;
          end
        end
        ST_PTR_ACK:   state_d = ST_WDATA;
        ST_WDATA_ACK: state_d = ST_WDATA;
        ST_RDATA_ACK: begin
          ptr_d = ptr_inc;
          if (!sda_s_q) begin
            sh_d    = mem_q[ptr_inc];
            state_d = ST_RDATA;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1_q   <= 1'b1;
      scl_s_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s_q    <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      sh_q       <= 8'h00;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      oe_q       <= 1'b0;
      pend_q     <= 1'b0;
      hold_q     <= '0;
      strobe_q   <= 1'b0;
      wa_q       <= '0;
      wd_q       <= 8'h00;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s_q    <= scl_s1_q;
      scl_prev_q <= scl_s_q;
      sda_s1_q   <= sda_i;
      sda_s_q    <= sda_s1_q;
      sda_prev_q <= sda_s_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      oe_q       <= oe_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      strobe_q   <= strobe_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[ptr_q] <= rx_byte;
    end
  end

  assign sda_o       = 1'b0;
  assign sda_o_en    = oe_q;
  assign busy        = busy_q;
  assign wr_strobe   = strobe_q;
  assign wr_addr     = wa_q;
  assign wr_data     = wd_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_amiq_i2c_ex_slave.sv
// ----------------------------------------------------------------------------
// tb_amiq_i2c_ex_slave
// Bit-banged I2C master driving amiq_i2c_ex_slave over an open-drain SDA
// model. A transaction-level register-file model (array + pointer) predicts
// read data, pointer values and the write-strobe stream.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_amiq_i2c_ex_slave;

  localparam int W = 12;  // {wr_addr, wr_data}
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WAIT_STOP = 4'd9;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_o, sda_o_en, busy, wr_strobe;
  logic [3:0] wr_addr, dbg_state, dbg_ptr;
  logic [7:0] wr_data;

  assign sda_bus = m_sda & ~sda_o_en;

  amiq_i2c_ex_slave dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .scl_i       (m_scl),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .sda_o_en    (sda_o_en),
    .busy        (busy),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // ---------------- scoreboard state ----------------
  int         n_cmp    = 0;
  int         n_mis    = 0;
  int         n_strobe = 0;
  int         oe_seen  = 0;
  logic       watch    = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [7:0] mem_m [16];
  int         ptr_m = 0;
  logic [7:0] wbuf [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-strobe monitor against the expected queue.
  always @(negedge clock) begin
    if (reset_n && wr_strobe) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        check("wr_strobe_unexpected", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {28'd0, wr_addr}, {28'd0, e[11:8]});
        check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
      end
    end
  end

  always @(negedge clock) if (watch && sda_o_en) oe_seen++;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b, output logic s);
    tick(10); m_sda = b;
    tick(10); m_scl = 1'b1;
    tick(10); s = sda_bus;
    tick(10); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (!m_scl) begin
      tick(10); m_sda = 1'b1;
      tick(10); m_scl = 1'b1;
      tick(20);
    end
    m_sda = 1'b0;
    tick(20); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(10); m_sda = 1'b0;
    tick(10); m_scl = 1'b1;
    tick(20); m_sda = 1'b1;
    tick(20);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      d = {d[6:0], s};
    end
    send_bit(~master_ack, s);
  endtask

  // Write n bytes from wbuf starting at the pointer held in pbyte.
  task automatic do_write(input logic [7:0] pbyte, input int n);
    logic ack;
    ptr_m = int'(pbyte[3:0]);
    for (int i = 0; i < n; i++) begin
      mem_m[ptr_m] = wbuf[i];
      exp_q.push_back({ptr_m[3:0], wbuf[i]});
      ptr_m = (ptr_m + 1) % 16;
    end
    i2c_start();
    write_byte(8'hA0, ack); check("wr_addr_ack", {31'd0, ack}, 32'd1);
    check("busy_after_match", {31'd0, busy}, 32'd1);
    write_byte(pbyte, ack); check("ptr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      check($sformatf("wdata_ack_%0d", i), {31'd0, ack}, 32'd1);
    end
    i2c_stop();
    check("busy_after_wstop", {31'd0, busy}, 32'd0);
    check("ptr_after_write", {28'd0, dbg_ptr}, ptr_m);
  endtask

  // Set pointer, repeated START, read n bytes (ACK all but the last).
  task automatic do_read(input logic [7:0] pbyte, input int n);
    logic ack;
    logic [7:0] d;
    int p;
    p = int'(pbyte[3:0]);
    i2c_start();
    write_byte(8'hA0, ack); check("rd_waddr_ack", {31'd0, ack}, 32'd1);
    write_byte(pbyte, ack); check("rd_ptr_ack", {31'd0, ack}, 32'd1);
    i2c_start();
    write_byte(8'hA1, ack); check("rd_raddr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, d);
      check($sformatf("rdata_%0d", (p + i) % 16), {24'd0, d}, {24'd0, mem_m[(p + i) % 16]});
    end
    check("state_wait_stop", {28'd0, dbg_state}, {28'd0, ST_WAIT_STOP});
    check("busy_before_rstop", {31'd0, busy}, 32'd1);
    i2c_stop();
    check("busy_after_rstop", {31'd0, busy}, 32'd0);
    ptr_m = (p + n) % 16;
    check("ptr_after_read", {28'd0, dbg_ptr}, ptr_m);
  endtask

  // Global time bound.
  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic ack, s;
    int   st0, cnt;
    logic [7:0] pb, hi;

    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;

    tick(5);
    reset_n = 1'b1;
    tick(5);
    check("rst_sda_o_en", {31'd0, sda_o_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_ptr", {28'd0, dbg_ptr}, 32'd0);
    check("rst_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    check("sda_o_const", {31'd0, sda_o}, 32'd0);

    // Basic write: pointer 3, data 11, 22 -> ptr 5.
    st0 = n_strobe;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(8'h03, 2);
    check("basic_strobes", n_strobe - st0, 32'd2);
    check("basic_ptr5", {28'd0, dbg_ptr}, 32'd5);

    // Repeated-START read of the same bytes.
    do_read(8'h03, 2);

    // Wrap at the top of the register file.
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    do_write(8'h0F, 2);
    do_read(8'h0F, 2);

    // Foreign address: no ACK, no drive, no write.
    st0 = n_strobe;
    oe_seen = 0;
    watch = 1'b1;
    i2c_start();
    write_byte(8'hA2, ack); check("foreign_addr_nack", {31'd0, ack}, 32'd0);
    check("foreign_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h05, ack); check("foreign_data_nack", {31'd0, ack}, 32'd0);
    i2c_stop();
    watch = 1'b0;
    check("foreign_no_drive", oe_seen, 32'd0);
    check("foreign_no_strobe", n_strobe - st0, 32'd0);
    check("foreign_state_idle", {28'd0, dbg_state}, {28'd0, ST_IDLE});

    // STOP four bits into a data byte: no write, pointer stays at 7.
    st0 = n_strobe;
    i2c_start();
    write_byte(8'hA0, ack); check("mid_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h07, ack); check("mid_ptr_ack", {31'd0, ack}, 32'd1);
    ptr_m = 7;
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
    i2c_stop();
    check("mid_state_idle", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    check("mid_ptr_kept", {28'd0, dbg_ptr}, ptr_m);
    check("mid_no_strobe", n_strobe - st0, 32'd0);
    wbuf[0] = 8'h5C;
    do_write(8'h07, 1);
    do_read(8'h06, 3);

    // Randomized write/read-back rounds; pointer upper bits are random.
    for (int r = 0; r < 4; r++) begin
      hi  = 8'($urandom_range(0, 15));
      pb  = {hi[3:0], 4'($urandom_range(0, 15))};
      cnt = $urandom_range(1, 4);
      for (int i = 0; i < cnt; i++) wbuf[i] = 8'($urandom);
      do_write(pb, cnt);
      hi  = 8'($urandom_range(0, 15));
      pb  = {hi[3:0], 4'($urandom_range(0, 15))};
      do_read(pb, $urandom_range(1, 4));
    end
    check("strobe_queue_drained", exp_q.size(), 32'd0);

    // Reset during a read while the slave is pulling SDA low.
    wbuf[0] = 8'h01;
    do_write(8'h02, 1);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    i2c_start();
    write_byte(8'hA1, ack); check("rst_rd_addr_ack", {31'd0, ack}, 32'd1);
    cnt = 0;
    while (!sda_o_en && cnt < 30) begin
      tick(1);
      cnt++;
    end
    check("rst_rd_drive_seen", {31'd0, sda_o_en}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_release", {31'd0, sda_o_en}, 32'd0);
    m_sda = 1'b1;
    tick(2);
    m_scl = 1'b1;
    tick(4);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    exp_q.delete();
    tick(5);
    check("post_rst_ptr", {28'd0, dbg_ptr}, 32'd0);
    do_read(8'h00, 16);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/amiq_i2c_ex_slave.md
Name: amiq_i2c_ex_slave

Overview:
- Synthesizable I2C target (slave) with a small byte register file.
- Drives the shared open-drain SDA line through an output/enable pair; it does not drive SCL and does not stretch the clock.
- Serves as the responder end for example benches that contain I2C master agents.
- A write transfer sets a register pointer and then writes bytes; a read transfer returns bytes starting at the pointer.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address matched against the address byte.
- MEM_DEPTH, 16, number of 8-bit registers; must be a power of 2, from 2 to 256.
- PTR_W, 4, pointer width; equals log2(MEM_DEPTH).
- HOLD_CYCLES, 4, clock cycles between the synced SCL falling edge and any change of sda_o_en.

Ports:
- clock  input  1  system clock; must run at 16x the SCL rate or faster.
- reset_n  input  1  asynchronous active-low reset.
- scl_i  input  1  resolved bus SCL.
- sda_i  input  1  resolved bus SDA.
- sda_o  output  1  SDA drive value; constant 1'b0.
- sda_o_en  output  1  1 = pull SDA low, 0 = release SDA.
- busy  output  1  high from an address-matched START until STOP.
- wr_strobe  output  1  one-cycle pulse per data byte written.
- wr_addr  output  PTR_W  register index of the write flagged by wr_strobe.
- wr_data  output  8  data of the write flagged by wr_strobe.

Behaviour:
- Reset: sda_o_en=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, ptr=0, all registers=8'h00, FSM=IDLE. Reset asserted mid-transfer releases SDA in the same cycle (asynchronous).
- Input sync: scl_i and sda_i each pass through a 2-flop synchronizer. Edge detects are taken on the synced values.
- START: synced SDA falls while synced SCL=1. Valid in any state, including as a repeated START. Action: FSM=ADDR, bit count=0, sda_o_en=0.
- STOP: synced SDA rises while synced SCL=1. Valid in any state. Action: FSM=IDLE, sda_o_en=0, busy=0.
- Bit order: bits are sampled on the synced SCL rising edge, MSB first. sda_o_en changes only HOLD_CYCLES after a synced SCL falling edge.
- ADDR state: collect 8 bits.
  - Match (byte[7:1]==SLAVE_ADDR): set busy=1 and go to ADDR_ACK. Assert sda_o_en after the next falling edge plus HOLD_CYCLES; hold it for the 9th clock.
  - Mismatch: go to WAIT_STOP with SDA untouched.
- End of ADDR_ACK (the 9th clock's falling edge plus hold):
  - R/W=0: release SDA and go to PTR.
  - R/W=1: load shift register with mem[ptr]; drive sda_o_en = ~bit7; go to RDATA.
- PTR state: collect 8 bits; ptr <= byte[PTR_W-1:0] (upper bits ignored). ACK, then go to WDATA.
- WDATA state: collect 8 bits. On the 8th rising edge:
  - mem[ptr] <= byte; wr_strobe=1 for one cycle with wr_addr=ptr and wr_data=byte.
  - ptr <= ptr+1, wrapping from MEM_DEPTH-1 to 0.
  - Every byte is ACKed. Stay in WDATA.
- RDATA state: after each falling edge plus hold, sda_o_en = ~next bit. After bit 0, release SDA for the 9th clock and sample the master ACK on its rising edge. ptr <= ptr+1 (wrapping) in either case.
  - ACK (0): load mem[ptr+1] and continue in RDATA.
  - NACK (1): go to WAIT_STOP.
- WAIT_STOP state: SDA released; only START or STOP are acted on.
- Simultaneous events: START/STOP detection takes priority over bit sampling in the same cycle. A STOP or START in mid-byte discards the partial byte, with no write and no ptr change.
- Register contents and ptr persist across transfers; only reset clears them.
- sda_o_en is never asserted while synced SCL=1 except during the ACK and read-data hold windows it started itself.

Test Plan:
- Write 8'hA0 (addr 7'h50, W), pointer 8'h03, data 8'h11, 8'h22 → ACK on all 4 bytes. wr_strobe pulses (3,8'h11) then (4,8'h22); ptr=5.
- Repeated-START read: write pointer 8'h03, repeated START, 8'hA1, read 2 bytes (master ACK then NACK) → returns 8'h11, 8'h22; WAIT_STOP; busy drops at STOP.
- Wrap: pointer 8'h0F, write 8'hAA, 8'hBB → mem[15]=8'hAA, mem[0]=8'hBB, wr_addr sequence 15,0. Read from pointer 8'h0F → returns AA then BB.
- Address 8'hA2 (7'h51) → no ACK (sda_o_en stays 0 for the whole transfer), busy=0, no wr_strobe.
- STOP after 4 bits of a data byte → no write, ptr unchanged, FSM=IDLE. A following transfer at addr 7'h50 works normally.
- reset_n low during a read while sda_o_en=1 → sda_o_en=0 immediately; after release all registers read 8'h00 and ptr=0.
